sdram_traffic_gen: RTL and testbench

Parametrised, self-checking traffic generator for the `sdram_controller` host interface. It replaces hand-timed bench stimulus with a repeatable sequence: write a programmable region with a data pattern, read it back, and compare. It counts mismatches and flags a hung controller. It sits between a start/status source (bench or board switches/LEDs) and the controller's host-side ports, and is synthesizable for on-board memory test.

---
 rtl/sdram_tg_pkg.sv | 53 +++++
 rtl/sdram_tg_pattern.sv | 53 +++++
 rtl/sdram_traffic_gen.sv | 183 ++++++++++++++++++
 tb/tb_sdram_traffic_gen.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_tg_pkg.sv
// Shared types and constants for the SDRAM traffic generator.
package sdram_tg_pkg;

    // FSM state encoding
    typedef logic [2:0] tg_state_t;
    localparam tg_state_t StIdle   = 3'd0;
    localparam tg_state_t StWrReq  = 3'd1;
    localparam tg_state_t StWrWait = 3'd2;
    localparam tg_state_t StRdReq  = 3'd3;
    localparam tg_state_t StRdWait = 3'd4;
    localparam tg_state_t StCheck  = 3'd5;
    localparam tg_state_t StDone   = 3'd6;

    // Data pattern modes
    localparam int unsigned PAT_INC   = 0;
    localparam int unsigned PAT_LFSR  = 1;
    localparam int unsigned PAT_NADDR = 2;

    // Maximal-length Galois (right-shift) feedback masks; zero for unsupported widths
    function automatic logic [31:0] lfsr_taps(input int unsigned width);
        logic [31:0] taps;
        case (width)
            8:       taps = 32'h0000_00B8;
            9:       taps = 32'h0000_0110;
            10:      taps = 32'h0000_0240;
            11:      taps = 32'h0000_0500;
            12:      taps = 32'h0000_0829;
            13:      taps = 32'h0000_100D;
            14:      taps = 32'h0000_2015;
            15:      taps = 32'h0000_6000;
            16:      taps = 32'h0000_B400;
            17:      taps = 32'h0001_2000;
            18:      taps = 32'h0002_0400;
            19:      taps = 32'h0004_0023;
            20:      taps = 32'h0009_0000;
            21:      taps = 32'h0014_0000;
            22:      taps = 32'h0030_0000;
            23:      taps = 32'h0042_0000;
            24:      taps = 32'h00E1_0000;
            25:      taps = 32'h0120_0000;
            26:      taps = 32'h0200_0023;
            27:      taps = 32'h0400_0013;
            28:      taps = 32'h0900_0000;
            29:      taps = 32'h1400_0000;
            30:      taps = 32'h2000_0029;
            31:      taps = 32'h4800_0000;
            32:      taps = 32'h8020_0003;
            default: taps = 32'h0000_0000;
        endcase
        return taps;
    endfunction

endpackage

// File: rtl/sdram_tg_pattern.sv
// Data pattern source: incrementing counter, Galois LFSR, or inverted address.
// 'pattern' always shows P(i) for the current word; 'load' restarts at P(0).
module sdram_tg_pattern
    import sdram_tg_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 24,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned PATTERN    = PAT_INC,
    parameter logic [31:0] SEED       = 32'd1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic                  step,
    input  logic [ADDR_WIDTH-1:0] addr,
    output logic [DATA_WIDTH-1:0] pattern
);

    localparam logic [31:0]           TAPS    = lfsr_taps(DATA_WIDTH);
    localparam logic [DATA_WIDTH-1:0] SEED_W  = DATA_WIDTH'(SEED);
    // An all-zero LFSR state never leaves zero
    localparam logic [DATA_WIDTH-1:0] SEED_NZ = (SEED_W == '0) ? DATA_WIDTH'(1) : SEED_W;

    function automatic logic [DATA_WIDTH-1:0] lfsr_next(input logic [DATA_WIDTH-1:0] x);
        return (x >> 1) ^ (x[0] ? TAPS[DATA_WIDTH-1:0] : '0);
    endfunction

    logic [DATA_WIDTH-1:0]            value_q, value_d;
    logic [ADDR_WIDTH+DATA_WIDTH-1:0] addr_ext;
    logic                             unused_addr_hi;

    assign addr_ext       = {{DATA_WIDTH{1'b0}}, addr};
    assign unused_addr_hi = ^addr_ext[ADDR_WIDTH+DATA_WIDTH-1:DATA_WIDTH];

    // Next generator value: the LFSR's first word is one step past the seed
    always_comb begin
        value_d = value_q;
        if (load) begin
            value_d = (PATTERN == PAT_LFSR) ? lfsr_next(SEED_NZ) : SEED_W;
        end else if (step) begin
            value_d = (PATTERN == PAT_LFSR) ? lfsr_next(value_q) : value_q + DATA_WIDTH'(1);
        end
    end

    // Generator state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) value_q <= '0;
        else        value_q <= value_d;
    end

    assign pattern = (PATTERN == PAT_NADDR) ? ~addr_ext[DATA_WIDTH-1:0] : value_q;

endmodule

// File: rtl/sdram_traffic_gen.sv
// Write/readback/compare traffic generator for the sdram_controller host port.
module sdram_traffic_gen
    import sdram_tg_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH  = 24,
    parameter int unsigned           DATA_WIDTH  = 16,
    parameter int unsigned           NUM_WORDS   = 256,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
    parameter logic [ADDR_WIDTH-1:0] ADDR_STRIDE = ADDR_WIDTH'(1),
    parameter int unsigned           PATTERN     = PAT_INC,
    parameter logic [31:0]           SEED        = 32'd1,
    parameter int unsigned           TIMEOUT     = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  done,
    output logic                  pass,
    output logic                  timeout,
    output logic [15:0]           err_count,
    output logic [ADDR_WIDTH-1:0] first_err_addr,
    output logic [ADDR_WIDTH-1:0] haddr,
    output logic [DATA_WIDTH-1:0] data_input,
    output logic                  wr_enable,
    output logic                  rd_enable,
    input  logic                  busy,
    input  logic [DATA_WIDTH-1:0] data_output
);

    localparam int unsigned      IDX_W    = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);
    localparam logic [31:0]      TMO_LAST = TIMEOUT - 1;

    tg_state_t             state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           cnt_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [15:0]           err_q, err_d;
    logic [ADDR_WIDTH-1:0] fea_q, fea_d;
    logic                  tmo_q, tmo_d;
    logic [ADDR_WIDTH-1:0] haddr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  wr_en_q, rd_en_q, done_q, pass_q;
    logic                  pat_load, pat_step, capture, in_hs, tmo_hit;
    logic [DATA_WIDTH-1:0] pattern;

    sdram_tg_pattern #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .PATTERN    (PATTERN),
        .SEED       (SEED)
    ) u_pattern (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (pat_load),
        .step    (pat_step),
        .addr    (addr_q),
        .pattern (pattern)
    );

    // Sequencing: handshake progress, word index/address and error bookkeeping
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        addr_d   = addr_q;
        err_d    = err_q;
        fea_d    = fea_q;
        tmo_d    = tmo_q;
        pat_load = 1'b0;
        pat_step = 1'b0;
        capture  = 1'b0;
        in_hs    = state_q inside {StWrReq, StWrWait, StRdReq, StRdWait};
        tmo_hit  = in_hs && (cnt_q >= TMO_LAST);

        case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d  = StWrReq;
                    idx_d    = '0;
                    addr_d   = BASE_ADDR;
                    err_d    = '0;
                    fea_d    = '0;
                    tmo_d    = 1'b0;
                    pat_load = 1'b1;
                end
            end
            // Only a busy seen while our request is visible counts as acceptance
            StWrReq: if (busy && wr_en_q) state_d = StWrWait;
            StWrWait: begin
                if (!busy) begin
                    if (idx_q == LAST_IDX) begin
                        idx_d    = '0;
                        addr_d   = BASE_ADDR;
                        pat_load = 1'b1;
                        state_d  = StRdReq;
                    end else begin
                        idx_d    = idx_q + IDX_W'(1);
                        addr_d   = addr_q + ADDR_STRIDE;
                        pat_step = 1'b1;
                        state_d  = StWrReq;
                    end
                end
            end
            StRdReq: if (busy && rd_en_q) state_d = StRdWait;
            StRdWait: begin
                if (!busy) begin
                    capture = 1'b1;
                    state_d = StCheck;
                end
            end
            StCheck: begin
                if (rdata_q != pattern) begin
                    if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
                    if (err_q == 16'd0)    fea_d = addr_q;
                end
                idx_d    = idx_q + IDX_W'(1);
                addr_d   = addr_q + ADDR_STRIDE;
                pat_step = 1'b1;
                state_d  = (idx_q == LAST_IDX) ? StDone : StRdReq;
            end
            default: state_d = StIdle;
        endcase

        if (tmo_hit) begin
            state_d  = StDone;
            tmo_d    = 1'b1;
            idx_d    = idx_q;
            addr_d   = addr_q;
            pat_load = 1'b0;
            pat_step = 1'b0;
            capture  = 1'b0;
        end
    end

    // State, bookkeeping and registered host-side outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            idx_q   <= '0;
            addr_q  <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= '0;
            fea_q   <= '0;
            tmo_q   <= 1'b0;
            haddr_q <= '0;
            wdata_q <= '0;
            wr_en_q <= 1'b0;
            rd_en_q <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            addr_q  <= addr_d;
            err_q   <= err_d;
            fea_q   <= fea_d;
            tmo_q   <= tmo_d;
            if (state_d != state_q) cnt_q <= '0;
            else if (cnt_q != '1)   cnt_q <= cnt_q + 32'd1;
            if (capture) rdata_q <= data_output;
            haddr_q <= addr_q;
            if (state_q == StWrReq) wdata_q <= pattern;
            // Request stays up until acceptance or timeout, one cycle after entering REQ
            wr_en_q <= (state_q == StWrReq) && (state_d == StWrReq);
            rd_en_q <= (state_q == StRdReq) && (state_d == StRdReq);
            done_q  <= (state_d == StDone);
            pass_q  <= (state_d == StDone) && (err_d == 16'd0) && !tmo_d;
        end
    end

    assign done           = done_q;
    assign pass           = pass_q;
    assign timeout        = tmo_q;
    assign err_count      = err_q;
    assign first_err_addr = fea_q;
    assign haddr          = haddr_q;
    assign data_input     = wdata_q;
    assign wr_enable      = wr_en_q;
    assign rd_enable      = rd_en_q;

endmodule

// File: tb/tb_sdram_traffic_gen.sv
// Scoreboard bench: four generator configurations share one controller model and monitor.
module tb_sdram_traffic_gen;

    localparam int unsigned NW_P   [4] = '{4, 16, 4, 4};
    localparam logic [23:0] BASE_P [4] = '{24'h000000, 24'h000000, 24'hFFFFFE, 24'h000000};
    localparam int unsigned PAT_P  [4] = '{0, 1, 2, 0};
    localparam logic [31:0] SEED_P [4] = '{32'h0D05, 32'h0, 32'h0D05, 32'h0D05};
    localparam int unsigned TO_P   [4] = '{1024, 1024, 1024, 8};

    localparam logic [15:0] EXP_INC  [4]  = '{16'h0D05, 16'h0D06, 16'h0D07, 16'h0D08};
    localparam logic [15:0] EXP_LFSR [16] = '{16'hB400, 16'h5A00, 16'h2D00, 16'h1680,
                                              16'h0B40, 16'h05A0, 16'h02D0, 16'h0168,
                                              16'h00B4, 16'h005A, 16'h002D, 16'hB416,
                                              16'h5A0B, 16'h9905, 16'hF882, 16'h7C41};
    localparam logic [23:0] WRAP_A   [4]  = '{24'hFFFFFE, 24'hFFFFFF, 24'h000000, 24'h000001};
    localparam logic [15:0] WRAP_D   [4]  = '{16'h0001, 16'h0000, 16'hFFFF, 16'hFFFE};

    logic clk, rst_n, start, hang, fault;
    int   sel;
    logic start_a [4], busy_a [4];
    logic done_a [4], pass_a [4], tmo_a [4], wr_a [4], rd_a [4];
    logic [15:0] err_a [4], din_a [4];
    logic [23:0] fea_a [4], haddr_a [4];
    logic [15:0] data_output;
    logic busy, busy_q;
    int   bcnt;
    logic [15:0] mem [256];

    logic done_s, pass_s, tmo_s, wr_s, rd_s;
    logic [15:0] err_s, din_s;
    logic [23:0] fea_s, haddr_s;

    typedef struct {
        int          kind;  // 0 write, 1 read, 2 status
        logic [23:0] addr;
        logic [15:0] data;
        logic        ok;
        logic        tmo;
        logic [15:0] errs;
        logic [23:0] fea;
    } ev_t;
    ev_t exp_q [$];

    int vectors = 0;
    int miscompares = 0;

    for (genvar k = 0; k < 4; k++) begin : g_dut
        sdram_traffic_gen #(
            .ADDR_WIDTH  (24),
            .DATA_WIDTH  (16),
            .NUM_WORDS   (NW_P[k]),
            .BASE_ADDR   (BASE_P[k]),
            .ADDR_STRIDE (24'd1),
            .PATTERN     (PAT_P[k]),
            .SEED        (SEED_P[k]),
            .TIMEOUT     (TO_P[k])
        ) u_dut (
            .clk            (clk),
            .rst_n          (rst_n),
            .start          (start_a[k]),
            .done           (done_a[k]),
            .pass           (pass_a[k]),
            .timeout        (tmo_a[k]),
            .err_count      (err_a[k]),
            .first_err_addr (fea_a[k]),
            .haddr          (haddr_a[k]),
            .data_input     (din_a[k]),
            .wr_enable      (wr_a[k]),
            .rd_enable      (rd_a[k]),
            .busy           (busy_a[k]),
            .data_output    (data_output)
        );
    end

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            start_a[k] = start && (sel == k);
            busy_a[k]  = busy && (sel == k);
        end
    end

    assign done_s  = done_a[sel];
    assign pass_s  = pass_a[sel];
    assign tmo_s   = tmo_a[sel];
    assign wr_s    = wr_a[sel];
    assign rd_s    = rd_a[sel];
    assign err_s   = err_a[sel];
    assign din_s   = din_a[sel];
    assign fea_s   = fea_a[sel];
    assign haddr_s = haddr_a[sel];
    assign busy    = hang || busy_q;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Controller model: accepts a request when idle, busy for 3 cycles, small memory
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= 1'b0;
            bcnt   <= 0;
        end else if (busy_q) begin
            if (bcnt == 0) busy_q <= 1'b0;
            else           bcnt   <= bcnt - 1;
        end else if (!hang && (wr_s || rd_s)) begin
            busy_q <= 1'b1;
            bcnt   <= 2;
            if (wr_s) mem[haddr_s[7:0]] <= din_s;
            else data_output <= mem[haddr_s[7:0]] ^
                                ((fault && haddr_s == 24'h000002) ? 16'h0001 : 16'h0000);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic push_ev(input int kind, input logic [23:0] a, input logic [15:0] d);
        ev_t e;
        e = '{kind: kind, addr: a, data: d, ok: 1'b0, tmo: 1'b0, errs: 16'h0, fea: 24'h0};
        exp_q.push_back(e);
    endtask

    task automatic push_status(input logic ok, input logic tmo, input logic [15:0] errs,
                               input logic [23:0] fea);
        ev_t e;
        e = '{kind: 2, addr: 24'h0, data: 16'h0, ok: ok, tmo: tmo, errs: errs, fea: fea};
        exp_q.push_back(e);
    endtask

    // Monitor: pops the scoreboard on each accepted request and on done rising
    initial begin
        logic done_prev;
        ev_t  e;
        done_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                chk("excl_enables", {31'b0, wr_s & rd_s}, 32'd0);
                for (int kind = 0; kind < 3; kind++) begin
                    if ((kind == 0 && wr_s && !busy) || (kind == 1 && rd_s && !busy) ||
                        (kind == 2 && done_s && !done_prev)) begin
                        if (exp_q.size() == 0) begin
                            chk("unexpected_event", kind, 32'hFFFF_FFFF);
                        end else begin
                            e = exp_q.pop_front();
                            chk("event_kind", kind, e.kind);
                            if (e.kind == kind && kind == 0) begin
                                chk("wr_addr", haddr_s, e.addr);
                                chk("wr_data", din_s, e.data);
                            end else if (e.kind == kind && kind == 1) begin
                                chk("rd_addr", haddr_s, e.addr);
                            end else if (e.kind == kind) begin
                                chk("st_pass", pass_s, e.ok);
                                chk("st_timeout", tmo_s, e.tmo);
                                chk("st_err_count", err_s, e.errs);
                                chk("st_first_err_addr", fea_s, e.fea);
                            end
                        end
                    end
                end
            end
            done_prev = done_s;
        end
    end

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int limit);
        int n;
        n = 0;
        while (!done_s && n < limit) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_done"}, done_s, 1);
        @(negedge clk);
        chk({name, "_drained"}, exp_q.size(), 0);
    endtask

    task automatic check_zero_outputs(input string name);
        chk({name, "_done"}, done_s, 0);
        chk({name, "_pass"}, pass_s, 0);
        chk({name, "_timeout"}, tmo_s, 0);
        chk({name, "_err_count"}, err_s, 0);
        chk({name, "_first_err"}, fea_s, 0);
        chk({name, "_haddr"}, haddr_s, 0);
        chk({name, "_data_input"}, din_s, 0);
        chk({name, "_wr_enable"}, wr_s, 0);
        chk({name, "_rd_enable"}, rd_s, 0);
    endtask

    task automatic push_inc_pass(input logic ok, input logic [15:0] errs, input logic [23:0] fea);
        for (int i = 0; i < 4; i++) push_ev(0, 24'(i), EXP_INC[i]);
        for (int i = 0; i < 4; i++) push_ev(1, 24'(i), 16'h0);
        push_status(ok, 1'b0, errs, fea);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int n;
        rst_n = 1'b0;
        start = 1'b0;
        hang  = 1'b0;
        fault = 1'b0;
        sel   = 0;
        #12;
        check_zero_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Clean pass, start latency, and an ignored mid-pass start
        push_inc_pass(1'b1, 16'h0, 24'h0);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_latency_edge_n", wr_s, 0);
        @(negedge clk);
        chk("start_latency_edge_n1", wr_s, 1);
        repeat (8) @(negedge clk);
        pulse_start();
        wait_done("clean", 500);

        // Fault injection at address 2
        fault = 1'b1;
        push_inc_pass(1'b0, 16'h1, 24'h000002);
        pulse_start();
        wait_done("fault", 500);
        fault = 1'b0;

        // LFSR round trip with zero seed
        sel = 1;
        for (int i = 0; i < 16; i++) push_ev(0, 24'(i), EXP_LFSR[i]);
        for (int i = 0; i < 16; i++) push_ev(1, 24'(i), 16'h0);
        push_status(1'b1, 1'b0, 16'h0, 24'h0);
        pulse_start();
        wait_done("lfsr", 1500);

        // Address wrap with inverted-address data
        sel = 2;
        for (int i = 0; i < 4; i++) push_ev(0, WRAP_A[i], WRAP_D[i]);
        for (int i = 0; i < 4; i++) push_ev(1, WRAP_A[i], 16'h0);
        push_status(1'b1, 1'b0, 16'h0, 24'h0);
        pulse_start();
        wait_done("wrap", 500);

        // Hung controller
        sel  = 3;
        hang = 1'b1;
        push_status(1'b0, 1'b1, 16'h0, 24'h0);
        pulse_start();
        n = 0;
        while (!wr_s && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("hang_first_wr_enable", wr_s, 1);
        n = 0;
        while (!done_s && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("hang_latency_window", {31'b0, (n >= 6 && n <= 12)}, 32'd1);
        chk("hang_timeout", tmo_s, 1);
        chk("hang_wr_low", wr_s, 0);
        chk("hang_rd_low", rd_s, 0);
        @(negedge clk);
        chk("hang_drained", exp_q.size(), 0);
        hang = 1'b0;

        // Reset during RD_WAIT, then a fresh pass
        sel = 0;
        for (int i = 0; i < 4; i++) push_ev(0, 24'(i), EXP_INC[i]);
        push_ev(1, 24'h0, 16'h0);
        pulse_start();
        n = 0;
        while (!(rd_s && !busy) && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("reach_first_read", {31'b0, rd_s && !busy}, 32'd1);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_zero_outputs("midpass_reset");
        @(negedge clk);
        chk("midpass_drained", exp_q.size(), 0);
        rst_n = 1'b1;
        @(negedge clk);
        push_inc_pass(1'b1, 16'h0, 24'h0);
        pulse_start();
        wait_done("restart", 500);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
